// File: rtl/ppu_apu_issuer.sv
// rtl/ppu_apu_issuer.sv - core-side posit APU request issuer with reserved result buffering
// Optional watchdog: define PPU_APU_ISSUER_TIMEOUT_EN.

module ppu_apu_issuer #(
    parameter int APU_NARGS       = 3,
    parameter int APU_WOP         = 6,
    parameter int APU_NDSFLAGS    = 15,
    parameter int APU_NUSFLAGS    = 5,
    parameter int TAG_W           = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [APU_NARGS*32-1:0]   cmd_operands_i,
    input  logic [APU_WOP-1:0]        cmd_op_i,
    input  logic [APU_NDSFLAGS-1:0]   cmd_flags_i,
    input  logic [TAG_W-1:0]          cmd_tag_i,
    output logic                      apu_req_o,
    input  logic                      apu_gnt_i,
    output logic [APU_NARGS*32-1:0]   apu_operands_o,
    output logic [APU_WOP-1:0]        apu_op_o,
    output logic [APU_NDSFLAGS-1:0]   apu_flags_o,
    input  logic                      apu_rvalid_i,
    input  logic [31:0]               apu_rdata_i,
    input  logic [APU_NUSFLAGS-1:0]   apu_rflags_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [31:0]               res_data_o,
    output logic [APU_NUSFLAGS-1:0]   res_flags_o,
    output logic [TAG_W-1:0]          res_tag_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW   = $clog2(RESP_DEPTH + 1);
    localparam int TPW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int RPW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int RW   = CW + OW + 1;
    localparam int RESW = TAG_W + 32 + APU_NUSFLAGS;

    localparam logic [RW-1:0]  RESP_LIM = RW'(RESP_DEPTH);
    localparam logic [OW:0]    OUT_LIM  = (OW + 1)'(MAX_OUTSTANDING);
    localparam logic [TPW-1:0] TAG_LAST = TPW'(MAX_OUTSTANDING - 1);
    localparam logic [RPW-1:0] RES_LAST = RPW'(RESP_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      ready_en_q;
    logic [APU_NARGS*32-1:0]   opr_q;
    logic [APU_WOP-1:0]        op_q;
    logic [APU_NDSFLAGS-1:0]   flags_q;
    logic [TAG_W-1:0]          tag_q;
    logic [OW-1:0]             out_q;
    logic [TAG_W-1:0]          tag_mem [MAX_OUTSTANDING];
    logic [TPW-1:0]            tag_wr_q, tag_rd_q;
    logic [RESW-1:0]           res_mem [RESP_DEPTH];
    logic [RPW-1:0]            res_wr_q, res_rd_q;
    logic [CW-1:0]             res_cnt_q;
    logic                      err_q;

    logic                      fire;
    logic                      accept;
    logic                      res_push;
    logic                      res_pop;
    logic                      timeout_hit;
    logic [RW-1:0]             reserved;
    logic [RW-1:0]             reserved_after;
    logic [OW:0]               out_after;

    // Space accounting: a held request, every granted request and every buffered
    // result each own one result slot, so responses can never overflow the FIFO.
    assign fire           = (state_q == REQ) && apu_gnt_i;
    assign res_pop        = res_valid_o && res_ready_i;
    assign res_push       = apu_rvalid_i && (out_q != '0);
    assign reserved       = RW'(state_q == REQ) + RW'(out_q) + RW'(res_cnt_q);
    assign reserved_after = reserved - RW'(fire) - RW'(res_pop);
    assign out_after      = {1'b0, out_q} + (OW + 1)'(fire);
    assign cmd_ready_o    = ready_en_q && !timeout_hit
                            && ((state_q == IDLE) || fire)
                            && (reserved_after < RESP_LIM)
                            && (out_after < OUT_LIM);
    assign accept         = cmd_valid_i && cmd_ready_o;

    assign apu_req_o      = (state_q == REQ);
    assign apu_operands_o = opr_q;
    assign apu_op_o       = op_q;
    assign apu_flags_o    = flags_q;
    assign res_valid_o    = (res_cnt_q != '0);
    assign {res_tag_o, res_data_o, res_flags_o} = res_mem[res_rd_q];
    assign busy_o         = (reserved != '0);
    assign err_o          = err_q;

`ifdef PPU_APU_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    // Watchdog counts only while responses are owed and restarts on each response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (apu_rvalid_i || (out_q == '0) || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Command acceptance is held off until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant either chains into the next accepted command or drops to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (fire)   state_d = accept ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    // Issue register: stays stable from acceptance until the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opr_q   <= '0;
            op_q    <= '0;
            flags_q <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            opr_q   <= cmd_operands_i;
            op_q    <= cmd_op_i;
            flags_q <= cmd_flags_i;
            tag_q   <= cmd_tag_i;
        end
    end

    // Outstanding count: grant adds one, matched response removes one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (timeout_hit) begin
            out_q <= '0;
        end else begin
            case ({fire, res_push})
                2'b10:   out_q <= out_q + 1'b1;
                2'b01:   out_q <= out_q - 1'b1;
                default: out_q <= out_q;
            endcase
        end
    end

    // Tag FIFO pointers: tags are queued at grant and retired by in-order responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else if (timeout_hit) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            if (fire)     tag_wr_q <= (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + 1'b1;
            if (res_push) tag_rd_q <= (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + 1'b1;
        end
    end

    // Tag FIFO storage.
    always_ff @(posedge clk_i) begin
        if (fire) tag_mem[tag_wr_q] <= tag_q;
    end

    // Result FIFO pointers and count; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (res_push) res_wr_q <= (res_wr_q == RES_LAST) ? '0 : res_wr_q + 1'b1;
            if (res_pop)  res_rd_q <= (res_rd_q == RES_LAST) ? '0 : res_rd_q + 1'b1;
            case ({res_push, res_pop})
                2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
                2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
                default: res_cnt_q <= res_cnt_q;
            endcase
        end
    end

    // Result FIFO storage: the response is tagged with the oldest outstanding tag.
    always_ff @(posedge clk_i) begin
        if (res_push) res_mem[res_wr_q] <= {tag_mem[tag_rd_q], apu_rdata_i, apu_rflags_i};
    end

    // Sticky error on an unsolicited response or a watchdog expiry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((apu_rvalid_i && (out_q == '0)) || timeout_hit) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_apu_issuer.sv
// tb/tb_ppu_apu_issuer.sv - self-checking bench for ppu_apu_issuer with queue-based reference model

module tb_ppu_apu_issuer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [95:0] cmd_operands_i;
    logic [5:0]  cmd_op_i;
    logic [14:0] cmd_flags_i;
    logic [4:0]  cmd_tag_i;
    logic        apu_req_o;
    logic        apu_gnt_i;
    logic [95:0] apu_operands_o;
    logic [5:0]  apu_op_o;
    logic [14:0] apu_flags_o;
    logic        apu_rvalid_i;
    logic [31:0] apu_rdata_i;
    logic [4:0]  apu_rflags_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic [4:0]  res_flags_o;
    logic [4:0]  res_tag_o;
    logic        busy_o;
    logic        err_o;

    ppu_apu_issuer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_operands_i (cmd_operands_i),
        .cmd_op_i       (cmd_op_i),
        .cmd_flags_i    (cmd_flags_i),
        .cmd_tag_i      (cmd_tag_i),
        .apu_req_o      (apu_req_o),
        .apu_gnt_i      (apu_gnt_i),
        .apu_operands_o (apu_operands_o),
        .apu_op_o       (apu_op_o),
        .apu_flags_o    (apu_flags_o),
        .apu_rvalid_i   (apu_rvalid_i),
        .apu_rdata_i    (apu_rdata_i),
        .apu_rflags_i   (apu_rflags_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .res_flags_o    (res_flags_o),
        .res_tag_o      (res_tag_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: the held request, the granted-tag queue and the result queue.
    logic        held;
    logic [95:0] h_opr;
    logic [5:0]  h_op;
    logic [14:0] h_fl;
    logic [4:0]  h_tag;
    logic [4:0]  tagq [$];
    logic [41:0] resq [$];
    logic        exp_err;
    logic        exp_ready;

    logic        fix_en;
    logic [95:0] fix_opr;
    logic [5:0]  fix_op;
    logic [14:0] fix_fl;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and compare all outputs with the model.
    task automatic drive(input logic cv, input logic [4:0] tg, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic rr);
        int          oc;
        int          rc;
        int          fire;
        int          pop;
        logic [41:0] hd;
        @(negedge clk_i);
        cmd_valid_i    = cv;
        cmd_tag_i      = tg;
        cmd_op_i       = fix_en ? fix_op  : 6'($urandom);
        cmd_operands_i = fix_en ? fix_opr : {$urandom, $urandom, $urandom};
        cmd_flags_i    = fix_en ? fix_fl  : 15'($urandom);
        apu_gnt_i      = gnt;
        apu_rvalid_i   = rv;
        apu_rdata_i    = rd;
        apu_rflags_i   = 5'($urandom);
        res_ready_i    = rr;
        #1;
        oc   = tagq.size();
        rc   = resq.size();
        fire = (held && gnt) ? 1 : 0;
        pop  = (rc > 0 && rr) ? 1 : 0;
        exp_ready = (!held || fire != 0) && ((int'(held) + oc + rc - fire - pop) < 4)
                    && ((oc + fire) < 2);
        chk("cmd_ready", cmd_ready_o, exp_ready);
        chk("apu_req", apu_req_o, held);
        if (held) begin
            chk("apu_operands", apu_operands_o, h_opr);
            chk("apu_op", apu_op_o, h_op);
            chk("apu_flags", apu_flags_o, h_fl);
        end
        chk("res_valid", res_valid_o, rc > 0);
        if (rc > 0) begin
            hd = resq[0];
            chk("res_tag", res_tag_o, hd[41:37]);
            chk("res_data", res_data_o, hd[36:5]);
            chk("res_flags", res_flags_o, hd[4:0]);
        end
        chk("busy", busy_o, held || oc > 0 || rc > 0);
        chk("err", err_o, exp_err);
    endtask

    // Advance the model by the handshakes of the current cycle, then let the clock edge pass.
    task automatic tick();
        logic       fire;
        logic       acc;
        logic [4:0] t;
        fire = held && apu_gnt_i;
        acc  = cmd_valid_i && exp_ready;
        if (resq.size() > 0 && res_ready_i) void'(resq.pop_front());
        if (apu_rvalid_i) begin
            if (tagq.size() > 0) begin
                t = tagq.pop_front();
                resq.push_back({t, apu_rdata_i, apu_rflags_i});
            end else begin
                exp_err = 1'b1;
            end
        end
        if (fire) begin
            tagq.push_back(h_tag);
            held = 1'b0;
        end
        if (acc) begin
            held  = 1'b1;
            h_opr = cmd_operands_i;
            h_op  = cmd_op_i;
            h_fl  = cmd_flags_i;
            h_tag = cmd_tag_i;
        end
        @(posedge clk_i);
    endtask

    task automatic model_reset();
        held    = 1'b0;
        exp_err = 1'b0;
        tagq.delete();
        resq.delete();
    endtask

    task automatic clear_inputs();
        cmd_valid_i    = 1'b0;
        cmd_operands_i = '0;
        cmd_op_i       = '0;
        cmd_flags_i    = '0;
        cmd_tag_i      = '0;
        apu_gnt_i      = 1'b0;
        apu_rvalid_i   = 1'b0;
        apu_rdata_i    = '0;
        apu_rflags_i   = '0;
        res_ready_i    = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        fix_en = 1'b0;
        fix_opr = '0;
        fix_op  = '0;
        fix_fl  = '0;
        clear_inputs();
        model_reset();

        // Reset values
        #3;
        chk("rst_apu_req", apu_req_o, 1'b0);
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_res_valid", res_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single op with grant in the first request cycle
        fix_en  = 1'b1;
        fix_opr = {32'h0, 32'h4000_0000, 32'h4000_0000};
        fix_op  = 6'h02;
        fix_fl  = 15'h0;
        drive(1, 5'd3, 0, 0, 0, 0); tick();
        fix_en = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        chk("single_req", apu_req_o, 1'b1);
        chk("single_op", apu_op_o, 6'h02);
        chk("single_opr", apu_operands_o, {32'h0, 32'h4000_0000, 32'h4000_0000});
        tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 32'h4800_0000, 0); tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("single_res_valid", res_valid_o, 1'b1);
        chk("single_res_tag", res_tag_o, 5'd3);
        chk("single_res_data", res_data_o, 32'h4800_0000);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("single_busy_clear", busy_o, 1'b0);
        tick();

        // Delayed grant: request and payload held, no new command accepted
        drive(1, 5'd10, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd11, 0, 0, 0, 0);
            chk("delay_ready", cmd_ready_o, 1'b0);
            chk("delay_req", apu_req_o, 1'b1);
            tick();
        end
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, $urandom, 0); tick();
        drive(0, 0, 0, 0, 0, 1); tick();

        // Credit limit: four buffered results block a fifth command until a pop
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(i + 16), 0, 0, 0, 0); tick();
            drive(0, 0, 1, 0, 0, 0); tick();
            drive(0, 0, 0, 1, $urandom, 0); tick();
        end
        drive(1, 5'd20, 0, 0, 0, 0);
        chk("credit_full", cmd_ready_o, 1'b0);
        tick();
        drive(1, 5'd20, 0, 0, 0, 1);
        chk("credit_pop_ready", cmd_ready_o, 1'b1);
        tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, $urandom, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1); tick();
        end

        // Outstanding cap: two grants, then tags come back in order
        drive(1, 5'd7, 0, 0, 0, 0); tick();
        drive(1, 5'd9, 1, 0, 0, 0); tick();
        drive(1, 5'd11, 1, 0, 0, 0);
        chk("cap_ready_after_two", cmd_ready_o, 1'b0);
        tick();
        drive(1, 5'd11, 1, 0, 0, 0);
        chk("cap_ready_idle", cmd_ready_o, 1'b0);
        chk("cap_req_idle", apu_req_o, 1'b0);
        tick();
        drive(0, 0, 0, 1, 32'hAAAA_0001, 0); tick();
        drive(0, 0, 0, 1, 32'hAAAA_0002, 0); tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("cap_tag_first", res_tag_o, 5'd7);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("cap_tag_second", res_tag_o, 5'd9);
        tick();

        // Grant and response in the same cycle
        drive(1, 5'd1, 0, 0, 0, 0); tick();
        drive(1, 5'd2, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 32'hBBBB_0001, 0); tick();
        drive(0, 0, 0, 1, 32'hBBBB_0002, 0); tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("sim_tag_first", res_tag_o, 5'd1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("sim_tag_second", res_tag_o, 5'd2);
        tick();

        // Unsolicited response sets the sticky error
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("unsol_err", err_o, 1'b1);
        chk("unsol_res_valid", res_valid_o, 1'b0);
        tick();

        // Reset in the middle of a request
        drive(1, 5'd4, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", apu_req_o, 1'b0);
        chk("midrst_err", err_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        model_reset();
        clear_inputs();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic cv;
            logic gnt;
            logic rv;
            logic rr;
            cv  = 1'($urandom_range(0, 1));
            gnt = 1'($urandom_range(0, 1));
            rv  = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
            rr  = ($urandom_range(0, 3) != 0);
            drive(cv, 5'($urandom), gnt, rv, $urandom, rr);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
